// File: rtl/maf_norm_sched_if.sv
// Handshake bundle for the MAF normalization-shift scheduler: operation input,
// shifter request channel and downstream result channel.
interface maf_norm_sched_if #(
  parameter int TAG_W = 4
);
  logic [2:0]       cont;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_lza;
  logic [5:0]       in_lza_h;
  logic [1:0]       revising;
  logic [TAG_W-1:0] in_tag;
  logic             sh_valid;
  logic             sh_ready;
  logic             sh_lane;
  logic [5:0]       sh_amt;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       out_amt;
  logic [5:0]       out_amt_h;
  logic             out_dual;
  logic [1:0]       out_clamp;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  cont, in_valid, in_lza, in_lza_h, revising, in_tag, sh_ready, out_ready,
    output in_ready, sh_valid, sh_lane, sh_amt,
    output out_valid, out_amt, out_amt_h, out_dual, out_clamp, out_tag
  );

  modport master (
    output cont, in_valid, in_lza, in_lza_h, revising, in_tag, sh_ready, out_ready,
    input  in_ready, sh_valid, sh_lane, sh_amt,
    input  out_valid, out_amt, out_amt_h, out_dual, out_clamp, out_tag
  );
endinterface

// File: rtl/maf_norm_sched.sv
// Corrects leading-one shift predictions per lane and time-shares the single
// normalization shifter: one pass in single-lane mode, two passes in dual mode.
module maf_norm_sched #(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  maf_norm_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE_LO = 2'd1,
    S_ISSUE_HI = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             dual_q, dual_d;
  logic [5:0]       amt0_q, amt0_d;
  logic [5:0]       amt1_q, amt1_d;
  logic [1:0]       clamp_q, clamp_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             in_ready_s;
  logic             sh_valid_s;
  logic             sh_lane_s;
  logic [5:0]       sh_amt_s;
  logic             out_valid_s;
  logic             accept_s;

  logic             dual_in_s;
  logic [5:0]       lim_s;
  logic [6:0]       sum0_s, sum1_s;
  logic             clamp0_in_s, clamp1_in_s;
  logic [5:0]       amt0_in_s, amt1_in_s;

  // Correction: 7-bit sums so the +1 from the revising bit never wraps before saturation.
  always_comb begin
    dual_in_s   = (bus.cont != 3'b000) && (bus.cont != 3'b010);
    lim_s       = dual_in_s ? 6'd27 : 6'd55;
    sum0_s      = {1'b0, bus.in_lza} + {6'd0, bus.revising[0]};
    sum1_s      = {1'b0, bus.in_lza_h} + {6'd0, bus.revising[1]};
    clamp0_in_s = (sum0_s > {1'b0, lim_s});
    amt0_in_s   = clamp0_in_s ? lim_s : sum0_s[5:0];
    if (dual_in_s) begin
      clamp1_in_s = (sum1_s > 7'd27);
      amt1_in_s   = clamp1_in_s ? 6'd27 : sum1_s[5:0];
    end else begin
      clamp1_in_s = 1'b0;
      amt1_in_s   = 6'd0;
    end
  end

  assign accept_s = bus.in_valid && in_ready_s;

  // State and operation registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dual_q  <= 1'b0;
      amt0_q  <= 6'd0;
      amt1_q  <= 6'd0;
      clamp_q <= 2'b00;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      dual_q  <= dual_d;
      amt0_q  <= amt0_d;
      amt1_q  <= amt1_d;
      clamp_q <= clamp_d;
      tag_q   <= tag_d;
    end
  end

  // Next-state and operation capture.
  always_comb begin
    state_d = state_q;
    dual_d  = dual_q;
    amt0_d  = amt0_q;
    amt1_d  = amt1_q;
    clamp_d = clamp_q;
    tag_d   = tag_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_ISSUE_LO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE_LO: begin
        if (bus.sh_ready) begin
          state_d = dual_q ? S_ISSUE_HI : S_DONE;
        end else begin
          state_d = S_ISSUE_LO;
        end
      end
      S_ISSUE_HI: begin
        if (bus.sh_ready) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE_HI;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = bus.in_valid ? S_ISSUE_LO : S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept_s) begin
      dual_d  = dual_in_s;
      amt0_d  = amt0_in_s;
      amt1_d  = amt1_in_s;
      clamp_d = {clamp1_in_s, clamp0_in_s};
      tag_d   = bus.in_tag;
    end else begin
      tag_d   = tag_q;
    end
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    in_ready_s  = 1'b0;
    sh_valid_s  = 1'b0;
    sh_lane_s   = 1'b0;
    sh_amt_s    = 6'd0;
    out_valid_s = 1'b0;
    case (state_q)
      S_IDLE:     in_ready_s = 1'b1;
      S_ISSUE_LO: begin
        sh_valid_s = 1'b1;
        sh_amt_s   = amt0_q;
      end
      S_ISSUE_HI: begin
        sh_valid_s = 1'b1;
        sh_lane_s  = 1'b1;
        sh_amt_s   = amt1_q;
      end
      S_DONE: begin
        out_valid_s = 1'b1;
        in_ready_s  = bus.out_ready;
      end
      default: in_ready_s = 1'b0;
    endcase
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.sh_valid  = sh_valid_s;
  assign bus.sh_lane   = sh_lane_s;
  assign bus.sh_amt    = sh_amt_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_amt   = amt0_q;
  assign bus.out_amt_h = amt1_q;
  assign bus.out_dual  = dual_q;
  assign bus.out_clamp = clamp_q;
  assign bus.out_tag   = tag_q;

endmodule

// File: tb/tb_maf_norm_sched.sv
// Directed bench for maf_norm_sched: arithmetic reference model with a per-cycle
// compare process, plus literal expectations at fixed cycle offsets.
module tb_maf_norm_sched;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maf_norm_sched_if #(.TAG_W(TAG_W)) bus();
  maf_norm_sched #(.TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int amt0;
    int amt1;
    int dual;
    int clamp;
    int tag;
  } res_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  res_t out_q[$];
  int   sh_lane_q[$];
  int   sh_amt_q[$];
  int   pop_cyc[$];
  int   pop_tag[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // What the result must be, straight from the correction rules.
  function automatic res_t model(input int c, input int lza, input int lzah, input int rev, input int tag);
    res_t r;
    int lim, s0, s1;
    r.dual  = (c == 0 || c == 2) ? 0 : 1;
    lim     = r.dual ? 27 : 55;
    s0      = lza + (rev % 2);
    r.amt0  = (s0 > lim) ? lim : s0;
    r.clamp = (s0 > lim) ? 1 : 0;
    r.amt1  = 0;
    if (r.dual) begin
      s1     = lzah + (rev / 2);
      r.amt1 = (s1 > 27) ? 27 : s1;
      if (s1 > 27) r.clamp += 2;
    end
    r.tag = tag;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle comparison of shifter requests and results against the model.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      out_q.delete();
      sh_lane_q.delete();
      sh_amt_q.delete();
    end else begin
      if (bus.sh_valid) begin
        chk("sh_and_out_overlap", int'(bus.out_valid), 0);
        if (sh_amt_q.size() == 0) begin
          chk("sh_unexpected", 1, 0);
        end else begin
          chk("sh_lane", int'(bus.sh_lane), sh_lane_q[0]);
          chk("sh_amt", int'(bus.sh_amt), sh_amt_q[0]);
          if (bus.sh_ready) begin
            void'(sh_lane_q.pop_front());
            void'(sh_amt_q.pop_front());
          end
        end
      end
      if (bus.out_valid) begin
        if (out_q.size() == 0) begin
          chk("out_unexpected", 1, 0);
        end else begin
          e = out_q[0];
          chk("out_amt", int'(bus.out_amt), e.amt0);
          chk("out_amt_h", int'(bus.out_amt_h), e.amt1);
          chk("out_dual", int'(bus.out_dual), e.dual);
          chk("out_clamp", int'(bus.out_clamp), e.clamp);
          chk("out_tag", int'(bus.out_tag), e.tag);
          if (bus.out_ready) begin
            void'(out_q.pop_front());
            pop_cyc.push_back(cyc);
            pop_tag.push_back(int'(bus.out_tag));
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(int'(bus.cont), int'(bus.in_lza), int'(bus.in_lza_h),
                  int'(bus.revising), int'(bus.in_tag));
        out_q.push_back(e);
        sh_lane_q.push_back(0);
        sh_amt_q.push_back(e.amt0);
        if (e.dual != 0) begin
          sh_lane_q.push_back(1);
          sh_amt_q.push_back(e.amt1);
        end
      end
    end
  end

  task automatic drive(input int c, input int lza, input int lzah, input int rev, input int tag);
    @(posedge clk);
    #1;
    bus.cont     = 3'(c);
    bus.in_lza   = 6'(lza);
    bus.in_lza_h = 6'(lzah);
    bus.revising = 2'(rev);
    bus.in_tag   = 4'(tag);
    bus.in_valid = 1'b1;
  endtask

  // Returns at the negedge of the accept cycle T.
  task automatic wait_accept(input string name);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    chk(name, int'(k < 20), 1);
  endtask

  task automatic release_in();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cont = 3'b000; bus.in_valid = 1'b0; bus.in_lza = 6'd0; bus.in_lza_h = 6'd0;
    bus.revising = 2'b00; bus.in_tag = 4'd0; bus.sh_ready = 1'b1; bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_sh_valid", int'(bus.sh_valid), 0);
    chk("rst_sh_lane", int'(bus.sh_lane), 0);
    chk("rst_sh_amt", int'(bus.sh_amt), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_amt", int'(bus.out_amt), 0);
    chk("rst_out_amt_h", int'(bus.out_amt_h), 0);
    chk("rst_out_dual", int'(bus.out_dual), 0);
    chk("rst_out_clamp", int'(bus.out_clamp), 0);
    chk("rst_out_tag", int'(bus.out_tag), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single-mode basic
    drive(0, 10, 0, 1, 5); wait_accept("acc_single"); release_in();
    @(negedge clk);
    chk("s_t1_sh_valid", int'(bus.sh_valid), 1);
    chk("s_t1_sh_lane", int'(bus.sh_lane), 0);
    chk("s_t1_sh_amt", int'(bus.sh_amt), 11);
    @(negedge clk);
    chk("s_t2_out_valid", int'(bus.out_valid), 1);
    chk("s_t2_out_amt", int'(bus.out_amt), 11);
    chk("s_t2_out_amt_h", int'(bus.out_amt_h), 0);
    chk("s_t2_out_dual", int'(bus.out_dual), 0);
    chk("s_t2_out_clamp", int'(bus.out_clamp), 0);
    chk("s_t2_out_tag", int'(bus.out_tag), 5);
    @(negedge clk);
    chk("s_t3_idle", int'(bus.out_valid), 0);

    // Dual-mode sequencing
    drive(3'b100, 5, 20, 2, 6); wait_accept("acc_dual"); release_in();
    @(negedge clk);
    chk("d_t1_lane", int'(bus.sh_lane), 0);
    chk("d_t1_amt", int'(bus.sh_amt), 5);
    @(negedge clk);
    chk("d_t2_sh_valid", int'(bus.sh_valid), 1);
    chk("d_t2_lane", int'(bus.sh_lane), 1);
    chk("d_t2_amt", int'(bus.sh_amt), 21);
    chk("d_t2_out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("d_t3_out_valid", int'(bus.out_valid), 1);
    chk("d_t3_out_amt", int'(bus.out_amt), 5);
    chk("d_t3_out_amt_h", int'(bus.out_amt_h), 21);
    chk("d_t3_out_dual", int'(bus.out_dual), 1);
    chk("d_t3_out_clamp", int'(bus.out_clamp), 0);

    // Saturation, single lane: boundary 55+1 and 63+1 (cont 010 is single; lane 1 ignored)
    drive(0, 55, 0, 1, 7); wait_accept("acc_sat_s"); release_in();
    repeat (2) @(negedge clk);
    chk("sat_s_amt", int'(bus.out_amt), 55);
    chk("sat_s_clamp", int'(bus.out_clamp), 1);
    drive(3'b010, 63, 30, 3, 2); wait_accept("acc_sat_s2"); release_in();
    repeat (2) @(negedge clk);
    chk("sat_s2_amt", int'(bus.out_amt), 55);
    chk("sat_s2_amt_h", int'(bus.out_amt_h), 0);
    chk("sat_s2_clamp", int'(bus.out_clamp), 1);
    chk("sat_s2_dual", int'(bus.out_dual), 0);

    // Saturation, dual lane; then 26+1 sits exactly at the limit without clamping
    drive(3'b111, 27, 27, 3, 8); wait_accept("acc_sat_d"); release_in();
    repeat (3) @(negedge clk);
    chk("sat_d_amt", int'(bus.out_amt), 27);
    chk("sat_d_amt_h", int'(bus.out_amt_h), 27);
    chk("sat_d_clamp", int'(bus.out_clamp), 3);
    drive(3'b001, 26, 0, 3, 3); wait_accept("acc_edge_d"); release_in();
    repeat (3) @(negedge clk);
    chk("edge_d_amt", int'(bus.out_amt), 27);
    chk("edge_d_amt_h", int'(bus.out_amt_h), 1);
    chk("edge_d_clamp", int'(bus.out_clamp), 0);

    // Shifter backpressure for 3 cycles; cont change mid-op must not matter
    drive(0, 30, 0, 0, 9); bus.sh_ready = 1'b0;
    wait_accept("acc_shbp"); release_in(); bus.cont = 3'b100;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("shbp_sh_valid", int'(bus.sh_valid), 1);
      chk("shbp_sh_amt", int'(bus.sh_amt), 30);
      chk("shbp_out_valid", int'(bus.out_valid), 0);
    end
    @(posedge clk); #1 bus.sh_ready = 1'b1; bus.cont = 3'b000;
    @(negedge clk);
    chk("shbp_t4_out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("shbp_t5_out_valid", int'(bus.out_valid), 1);
    chk("shbp_t5_dual", int'(bus.out_dual), 0);

    // Output backpressure for 4 cycles
    drive(0, 40, 0, 1, 10); bus.out_ready = 1'b0;
    wait_accept("acc_obp"); release_in();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("obp_out_valid", int'(bus.out_valid), 1);
      chk("obp_in_ready", int'(bus.in_ready), 0);
      chk("obp_out_amt", int'(bus.out_amt), 41);
      chk("obp_out_tag", int'(bus.out_tag), 10);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("obp_pop_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    chk("obp_after_pop", int'(bus.out_valid), 0);

    // Back-to-back single-mode ops tagged 1, 2, 3
    pop_cyc.delete(); pop_tag.delete();
    drive(0, 1, 0, 0, 1);
    for (int i = 1; i <= 3; i++) begin
      wait_accept("acc_b2b");
      @(posedge clk); #1;
      if (i < 3) begin
        bus.in_lza = 6'(i + 1);
        bus.in_tag = 4'(i + 1);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    repeat (6) @(negedge clk);
    chk("b2b_count", pop_tag.size(), 3);
    if (pop_tag.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("b2b_tag", pop_tag[i], i + 1);
      chk("b2b_gap1", pop_cyc[1] - pop_cyc[0], 2);
      chk("b2b_gap2", pop_cyc[2] - pop_cyc[1], 2);
    end

    // Reset during ISSUE_HI
    drive(3'b100, 3, 4, 0, 9); wait_accept("acc_rst"); release_in();
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_lane", int'(bus.sh_lane), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_sh_valid", int'(bus.sh_valid), 0);
    chk("rst_mid_out_valid", int'(bus.out_valid), 0);
    chk("rst_mid_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_post_in_ready", int'(bus.in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_post_out_valid", int'(bus.out_valid), 0);
      chk("rst_post_sh_valid", int'(bus.sh_valid), 0);
    end

    chk("end_out_q_empty", out_q.size(), 0);
    chk("end_sh_q_empty", sh_amt_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/maf_norm_sched.md
# maf_norm_sched

Normalization-shift scheduler for the multi-precision MAF datapath. It accepts one operation per handshake, carrying the leading-one predicted shift amounts and the `revising[1:0]` correction bits produced by the leading-one correction tree. It forms the corrected shift amount per lane and time-shares the single 56-bit normalization shifter between lanes: one pass in single-lane modes, two sequential passes in dual half-precision mode. It then presents the final per-lane amounts downstream with a valid/ready handshake.

## Interface
Parameters:
- `TAG_W`, default 4: width of the operation tag carried through unchanged.

Ports:
- `clk`  in  1  — clock; one clock domain.
- `rst`  in  1  — reset; asynchronous, active-high.
- `cont`  in  3  — precision mode. 3'b000 and 3'b010 mean single lane (56-bit field). All other values mean dual lane (two 28-bit fields).
- `in_valid`  in  1  — an operation is offered.
- `in_ready`  out  1  — the block can accept an operation.
- `in_lza`  in  6  — predicted shift, lane 0 (low).
- `in_lza_h`  in  6  — predicted shift, lane 1 (high). Used only in dual mode.
- `revising`  in  2  — correction bits. Bit 0 is for lane 0 or the single lane; bit 1 is for lane 1. Valid in the same cycle as `in_valid`.
- `in_tag`  in  TAG_W  — operation tag.
- `sh_valid`  out  1  — shifter request.
- `sh_ready`  in  1  — shifter accepts the request.
- `sh_lane`  out  1  — 0 = low lane or single lane; 1 = high lane.
- `sh_amt`  out  6  — corrected shift amount for the current pass.
- `out_valid`  out  1  — result available.
- `out_ready`  in  1  — downstream accepts the result.
- `out_amt`  out  6  — corrected amount, lane 0.
- `out_amt_h`  out  6  — corrected amount, lane 1. Zero in single mode.
- `out_dual`  out  1  — the operation was dual mode.
- `out_clamp`  out  2  — per-lane saturation flag.
- `out_tag`  out  TAG_W  — tag of the operation.

## Operation
- Accept condition: `in_valid && in_ready`. On accept, register `cont` decode (dual), both corrected amounts, clamp flags and tag. Inputs are ignored from then on; a change on `cont` mid-operation has no effect.
- Correction arithmetic uses 7-bit intermediates:
  - Single mode: amt0 = in_lza + revising[0], saturated at 55. Clamp[0] is set if in_lza + revising[0] > 55. amt1 = 0 and clamp[1] = 0; revising[1] and in_lza_h are ignored.
  - Dual mode: amt0 = in_lza + revising[0], saturated at 27. amt1 = in_lza_h + revising[1], saturated at 27. Each lane sets its own clamp bit.
- State machine (IDLE, ISSUE_LO, ISSUE_HI, DONE):
  - IDLE: `in_ready` = 1. On accept, go to ISSUE_LO.
  - ISSUE_LO: `sh_valid` = 1, `sh_lane` = 0, `sh_amt` = amt0. When `sh_ready` is high, go to ISSUE_HI if dual, otherwise to DONE. If `sh_ready` is low, hold with all shifter outputs stable.
  - ISSUE_HI: `sh_valid` = 1, `sh_lane` = 1, `sh_amt` = amt1. When `sh_ready` is high, go to DONE. Otherwise hold.
  - DONE: `out_valid` = 1 with all out_* fields stable until `out_ready`.
    - `out_ready` high and `in_valid` high: pop the result and accept the next operation in the same cycle, then go to ISSUE_LO.
    - `out_ready` high and `in_valid` low: go to IDLE.
    - `in_ready` in DONE equals `out_ready`.
- `sh_valid` is never asserted in IDLE or DONE.
- Out fields are driven from registers only; there is no combinational path from in_* to out_*.
- Reset (asynchronous, any state): state goes to IDLE and any in-flight operation is discarded. `in_ready` goes to 1; `sh_valid`, `sh_lane`, `sh_amt`, `out_valid`, `out_amt`, `out_amt_h`, `out_dual`, `out_clamp` and `out_tag` all go to 0.

## Timing
- Accept at cycle T. `sh_valid` is high at T+1.
- Single mode with `sh_ready` always high: `out_valid` at T+2.
- Dual mode with `sh_ready` always high: lane-1 request at T+2, `out_valid` at T+3.
- Each low cycle of `sh_ready` adds one cycle of latency.
- Throughput with `out_ready` held high and no shifter stall: one operation per 2 cycles in single mode, one per 3 cycles in dual mode.
- `in_ready` is a function of the registered state and `out_ready` only. It does not depend on `in_valid`.

## Test plan
- Single-mode basic: cont=000, in_lza=10, revising=2'b01. Expect sh_lane=0 and sh_amt=11 at T+1; out_valid at T+2 with out_amt=11, out_amt_h=0, out_dual=0, out_clamp=00.
- Dual-mode sequencing: cont=3'b100, in_lza=5, in_lza_h=20, revising=2'b10. Expect sh_amt=5 (lane 0) at T+1, sh_amt=21 (lane 1) at T+2; out_valid at T+3 with out_amt=5, out_amt_h=21, out_dual=1.
- Saturation:
  - Single mode, in_lza=55, revising[0]=1: out_amt=55, out_clamp=01.
  - Dual mode, in_lza=27 and in_lza_h=27, revising=11: both amounts 27, out_clamp=11.
- Backpressure:
  - Hold sh_ready=0 for 3 cycles in ISSUE_LO: sh_valid and sh_amt stay stable, out_valid is delayed by 3 cycles.
  - Hold out_ready=0 for 4 cycles: out fields stay stable and in_ready=0.
- Back-to-back: keep in_valid and out_ready high with three single-mode ops tagged 1, 2, 3. Expect results on out_valid every 2 cycles, with tags in order 1, 2, 3 and none dropped.
- Reset mid-operation: assert rst during ISSUE_HI. In the same cycle sh_valid=0 and out_valid=0. After release, in_ready=1 and the discarded op never appears at the output.
